// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of signals between the fetch sequencer, instruction memory, decode and control.
// master = fetch controller; slave = the environment around it.
interface imem_fetch_ctrl_if;
  logic        start;
  logic        halt_req;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        busy;
  logic        done;
  logic        fault;
  logic [15:0] fetch_count;

  modport master (
    input  start, halt_req, id_stall, redirect_valid, redirect_pc, imem_instr,
    output imem_addr, if_instr, if_pc, if_valid, busy, done, fault, fetch_count
  );

  modport slave (
    output start, halt_req, id_stall, redirect_valid, redirect_pc, imem_instr,
    input  imem_addr, if_instr, if_pc, if_valid, busy, done, fault, fetch_count
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the big-endian instruction memory and
// registers one instruction per cycle for decode. Option: IMEM_BOUNDS_CHECK_EN.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'd100,
  parameter int unsigned MEM_BYTES    = 16384,
  parameter bit          STOP_ON_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  imem_fetch_ctrl_if.master bus
);

  localparam logic [31:0] MEM_SIZE = 32'(MEM_BYTES);
  localparam logic [31:0] MEM_LAST = 32'(MEM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_HALT  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;
  logic        if_valid_q;
  logic [15:0] count_q;

  logic        do_fetch;
  logic        do_redirect;
  logic        do_kill;
  logic        bounds_err;
  logic [31:0] pc_inc;
  logic [31:0] pc_next;
  logic [31:0] redirect_tgt;

  assign pc_inc = pc_q + 32'd4;

`ifdef IMEM_BOUNDS_CHECK_EN
  assign bounds_err   = (pc_q[1:0] != 2'b00) || ((pc_q + 32'd3) > MEM_LAST);
  assign pc_next      = pc_inc;
  assign redirect_tgt = bus.redirect_pc;
`else
  // Without the checker the PC is kept word-aligned and wrapped inside memory.
  assign bounds_err   = 1'b0;
  assign pc_next      = (pc_inc >= MEM_SIZE) ? '0 : pc_inc;
  assign redirect_tgt = bus.redirect_pc & ~32'd3;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath actions, in RUN priority order
  always_comb begin
    state_d     = state_q;
    do_fetch    = 1'b0;
    do_redirect = 1'b0;
    do_kill     = 1'b0;
    case (state_q)
      S_IDLE, S_HALT, S_DONE: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.halt_req) begin
          state_d = S_HALT;
          do_kill = 1'b1;
        end else if (bus.redirect_valid) begin
          do_redirect = 1'b1;
          do_kill     = 1'b1;
        end else if (bounds_err) begin
          state_d = S_FAULT;
          do_kill = 1'b1;
        end else if (STOP_ON_ZERO && (bus.imem_instr == '0)) begin
          state_d = S_DONE;
          do_kill = 1'b1;
        end else if (!bus.id_stall) begin
          do_fetch = 1'b1;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    bus.busy = (state_q == S_RUN);
    bus.done = (state_q == S_DONE);
`ifdef IMEM_BOUNDS_CHECK_EN
    bus.fault = (state_q == S_FAULT);
`else
    bus.fault = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      if (do_kill)     if_valid_q <= 1'b0;
      if (do_redirect) pc_q       <= redirect_tgt;
      if (do_fetch) begin
        if_instr_q <= bus.imem_instr;
        if_pc_q    <= pc_q;
        if_valid_q <= 1'b1;
        pc_q       <= pc_next;
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      end
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus random
// stimulus, compared each cycle against a behavioural fetch model.
module tb_imem_fetch_ctrl;

  localparam int unsigned MEM_BYTES = 16384;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(
    .RESET_PC    (32'd100),
    .MEM_BYTES   (MEM_BYTES),
    .STOP_ON_ZERO(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  logic [31:0] mem [MEM_BYTES/4];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr < 32'(MEM_BYTES)) return mem[addr[13:2]];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb bus.imem_instr = mem_word(bus.imem_addr);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 run, 2 halted, 3 done, 4 faulted
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_ifpc;
  logic        m_valid;
  int          m_count;

  task automatic model_step();
    logic [31:0] w;
    if (reset) begin
      m_mode = 0; m_pc = 32'd100; m_instr = 0; m_ifpc = 0; m_valid = 0; m_count = 0;
      return;
    end
    w = mem_word(m_pc);
    case (m_mode)
      0, 2, 3: if (bus.start) m_mode = 1;
      1: begin
        if (bus.halt_req) begin
          m_valid = 0; m_mode = 2;
        end else if (bus.redirect_valid) begin
`ifdef IMEM_BOUNDS_CHECK_EN
          m_pc = bus.redirect_pc;
`else
          m_pc = {bus.redirect_pc[31:2], 2'b00};
`endif
          m_valid = 0;
        end
`ifdef IMEM_BOUNDS_CHECK_EN
        else if ((m_pc % 4 != 0) || (m_pc + 32'd3 > 32'(MEM_BYTES - 1))) begin
          m_mode = 4; m_valid = 0;
        end
`endif
        else if (w == 0) begin
          m_mode = 3; m_valid = 0;
        end else if (!bus.id_stall) begin
          m_instr = w; m_ifpc = m_pc; m_valid = 1;
          m_pc = m_pc + 32'd4;
`ifndef IMEM_BOUNDS_CHECK_EN
          if (m_pc >= 32'(MEM_BYTES)) m_pc = 0;
`endif
          if (m_count < 65535) m_count++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check_eq("imem_addr", bus.imem_addr, m_pc);
    check_eq("if_valid", 32'(bus.if_valid), 32'(m_valid));
    check_eq("if_instr", bus.if_instr, m_instr);
    check_eq("if_pc", bus.if_pc, m_ifpc);
    check_eq("busy", 32'(bus.busy), 32'(m_mode == 1));
    check_eq("done", 32'(bus.done), 32'(m_mode == 3));
    check_eq("fault", 32'(bus.fault), 32'(m_mode == 4));
    check_eq("fetch_count", 32'(bus.fetch_count), 32'(m_count));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    reset = 0; bus.start = 0; bus.halt_req = 0; bus.id_stall = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1; tick(); bus.start = 0;
  endtask

  initial begin
    for (int unsigned i = 0; i < MEM_BYTES / 4; i++) mem[i] = $urandom | 32'h1;
    mem[25] = 32'h4808_0000;
    mem[26] = 32'h4809_0004;
    for (int unsigned i = 150; i < 155; i++) mem[i] = 32'h2413_000F + 32'(i - 150);
    mem[155] = 32'h0;
    idle_inputs();
    m_mode = 0; m_pc = 100; m_instr = 0; m_ifpc = 0; m_valid = 0; m_count = 0;

    do_reset();
    check_eq("rst_addr", bus.imem_addr, 32'd100);
    check_eq("rst_valid", 32'(bus.if_valid), 32'd0);
    check_eq("rst_count", 32'(bus.fetch_count), 32'd0);

    // Sequential fetch and stall
    pulse_start();
    tick();
    check_eq("seq_pc0", bus.if_pc, 32'd100);
    check_eq("seq_in0", bus.if_instr, 32'h4808_0000);
    tick();
    check_eq("seq_pc1", bus.if_pc, 32'd104);
    check_eq("seq_in1", bus.if_instr, 32'h4809_0004);
    check_eq("seq_cnt", 32'(bus.fetch_count), 32'd2);
    bus.id_stall = 1;
    repeat (3) begin
      tick();
      check_eq("stall_pc", bus.if_pc, 32'd104);
      check_eq("stall_cnt", 32'(bus.fetch_count), 32'd2);
    end
    bus.id_stall = 0;
    tick();
    check_eq("unstall_pc", bus.if_pc, 32'd108);

    // Redirect bubble and end-of-program
    do_reset();
    bus.start = 1; tick(); bus.start = 0;
    bus.redirect_valid = 1; bus.redirect_pc = 32'd600; tick();
    bus.redirect_valid = 0;
    check_eq("redir_valid", 32'(bus.if_valid), 32'd0);
    check_eq("redir_addr", bus.imem_addr, 32'd600);
    tick();
    check_eq("redir_pc", bus.if_pc, 32'd600);
    check_eq("redir_in", bus.if_instr, 32'h2413_000F);
    repeat (5) tick();
    check_eq("eop_done", 32'(bus.done), 32'd1);
    check_eq("eop_valid", 32'(bus.if_valid), 32'd0);
    check_eq("eop_addr", bus.imem_addr, 32'd620);
    check_eq("eop_cnt", 32'(bus.fetch_count), 32'd5);
    pulse_start();
    tick();
    check_eq("refetch_done", 32'(bus.done), 32'd1);

    // Out-of-range redirect
    pulse_start();
    bus.redirect_valid = 1; bus.redirect_pc = 32'd16382; tick();
    bus.redirect_valid = 0;
    tick();
`ifdef IMEM_BOUNDS_CHECK_EN
    check_eq("oob_fault", 32'(bus.fault), 32'd1);
    check_eq("oob_addr", bus.imem_addr, 32'd16382);
    pulse_start();
    tick();
    check_eq("oob_sticky", 32'(bus.fault), 32'd1);
    do_reset();
    check_eq("oob_clr", 32'(bus.fault), 32'd0);
    check_eq("oob_pc", bus.imem_addr, 32'd100);
`else
    check_eq("wrap_pc", bus.if_pc, 32'd16380);
    check_eq("wrap_addr", bus.imem_addr, 32'd0);
    check_eq("wrap_fault", 32'(bus.fault), 32'd0);
`endif

    // Reset mid-run with a live instruction
    do_reset();
    pulse_start();
    tick();
    check_eq("mid_valid", 32'(bus.if_valid), 32'd1);
    reset = 1; tick(); reset = 0;
    check_eq("mid_rst_valid", 32'(bus.if_valid), 32'd0);
    check_eq("mid_rst_addr", bus.imem_addr, 32'd100);
    check_eq("mid_rst_cnt", 32'(bus.fetch_count), 32'd0);

    // Random traffic, with a sprinkling of zero words
    for (int unsigned i = 0; i < 64; i++) mem[$urandom_range(MEM_BYTES / 4 - 1)] = 32'h0;
    for (int n = 0; n < 4000; n++) begin
      reset              = ($urandom_range(149) == 0);
      bus.start          = ($urandom_range(5) == 0);
      bus.halt_req       = ($urandom_range(39) == 0);
      bus.id_stall       = ($urandom_range(3) == 0);
      bus.redirect_valid = ($urandom_range(11) == 0);
      if ($urandom_range(15) == 0) bus.redirect_pc = $urandom_range(MEM_BYTES + 64);
      else                         bus.redirect_pc = 32'($urandom_range(MEM_BYTES / 4 - 1)) << 2;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
